// File: rtl/multistage_switch_if.sv
// Bundles the button input and the stage outputs of multistage_switch.
//   pressed : button level, sampled on posedge clk (driven by master)
//   on      : one-hot stage, bit0 = OFF             (driven by slave)
//   level   : binary stage index                    (driven by slave)
//   adv     : one-cycle pulse after a level increase (driven by slave)
interface multistage_switch_if #(
  parameter int unsigned N_STAGES = 3
);
  localparam int unsigned LW = $clog2(N_STAGES);

  logic                pressed;
  logic [N_STAGES-1:0] on;
  logic [LW-1:0]       level;
  logic                adv;

  modport master (output pressed, input on, level, adv);
  modport slave  (input pressed, output on, level, adv);
endinterface

// File: rtl/multistage_switch.sv
// N-stage press-duration switch. Counts consecutive pressed cycles and steps through stages
// OFF, ON1 .. ON(N-1) at T1, T1+TSTEP, ... pressed edges. Releases are debounced over DEBOUNCE
// low edges; with STICKY=1 the level survives a confirmed release until the next press.
//   clk : clock, all state on posedge
//   rst : asynchronous, active-high reset
//   sw  : slave modport carrying pressed (in) and on/level/adv (out), all outputs registered
module multistage_switch #(
  parameter int unsigned N_STAGES = 3,
  parameter int unsigned T1       = 10,
  parameter int unsigned TSTEP    = 5,
  parameter int unsigned DEBOUNCE = 2,
  parameter int unsigned STICKY   = 0,
  parameter int unsigned CW       = 5
) (
  input logic                 clk,
  input logic                 rst,
  multistage_switch_if.slave  sw
);

  localparam int unsigned LW     = $clog2(N_STAGES);
  localparam int unsigned RW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned CMAX   = T1 + (N_STAGES - 2) * TSTEP;
  localparam int unsigned CW_TOP = (1 << CW) - 1;

  localparam logic [CW-1:0]       C_MAX  = CW'(CMAX);
  localparam logic [RW-1:0]       RC_MAX = RW'(DEBOUNCE);
  localparam logic [N_STAGES-1:0] ON_OFF = {{(N_STAGES - 1){1'b0}}, 1'b1};

  if (CW_TOP < CMAX) begin : g_cw_check
    $error("multistage_switch: CW too narrow to hold T1+(N_STAGES-2)*TSTEP");
  end

  logic [CW-1:0]       r_c;
  logic [RW-1:0]       r_rc;
  logic [LW-1:0]       r_level;
  logic [N_STAGES-1:0] r_on;
  logic                r_adv;

  logic [CW-1:0]       w_c_next;
  logic [RW-1:0]       w_rc_next;
  logic [LW-1:0]       w_level_next;

  // Stage reached after c consecutive pressed edges, capped at the top stage.
  function automatic logic [LW-1:0] f_stage(input logic [CW-1:0] c);
    int unsigned v;
    int unsigned s;
    v = 32'(c);
    if (v < T1) s = 0;
    else        s = 1 + (v - T1) / TSTEP;
    if (s > N_STAGES - 1) s = N_STAGES - 1;
    return LW'(s);
  endfunction

  always_comb begin
    w_c_next     = r_c;
    w_rc_next    = r_rc;
    w_level_next = r_level;
    if (sw.pressed) begin
      w_rc_next = '0;
      if (r_c < C_MAX) w_c_next = r_c + CW'(1);
      // r_rc at its max means a release was confirmed; a sticky level is dropped on re-press.
      if (STICKY != 0 && r_rc == RC_MAX) w_level_next = '0;
      else                               w_level_next = f_stage(w_c_next);
    end else begin
      if (r_rc < RC_MAX) w_rc_next = r_rc + RW'(1);
      // Short lows below the debounce count leave c untouched (glitch).
      if (w_rc_next == RC_MAX) w_c_next = '0;
      if (!(STICKY != 0 && w_rc_next == RC_MAX)) w_level_next = f_stage(w_c_next);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c     <= '0;
      r_rc    <= '0;
      r_level <= '0;
      r_on    <= ON_OFF;
      r_adv   <= 1'b0;
    end else begin
      r_c     <= w_c_next;
      r_rc    <= w_rc_next;
      r_level <= w_level_next;
      r_on    <= ON_OFF << w_level_next;
      r_adv   <= (w_level_next > r_level);
    end
  end

  assign sw.on    = r_on;
  assign sw.level = r_level;
  assign sw.adv   = r_adv;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot(r_on));
  a_on_lvl : assert property (@(posedge clk) disable iff (rst) r_on == (ON_OFF << r_level));

endmodule
